// File: rtl/i2c_reg_poller.sv
// Periodic multi-byte register poller in front of the I2C master handshake.
// Each byte is a pointer write followed by a one-byte read; the assembled sample is strobed out.
module i2c_reg_poller #(
    parameter logic [6:0]  DEV_ADDR = 7'h29,
    parameter logic [7:0]  REG_BASE = 8'h00,
    parameter int unsigned NBYTES   = 2,
    parameter int unsigned POLL_DIV = 20000,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                  clk_200k,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  i2c_req,
    output logic                  i2c_dir,
    output logic [6:0]            i2c_addr,
    output logic [7:0]            i2c_dat_to_slv,
    input  logic                  i2c_done,
    input  logic [7:0]            i2c_dat_from_slv,
    output logic [8*NBYTES-1:0]   sample,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned CNTW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(POLL_DIV - 1);
    localparam logic [WDW-1:0]  WD_MAX   = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_CLR,
        RD_REQ,
        RD_CLR,
        EMIT
    } state_t;

    state_t state, state_next;

    logic [CNTW-1:0]     poll_cnt;
    logic                tick;
    logic [WDW-1:0]      wd;
    logic                wd_expired;
    logic                abort;
    logic [IDXW-1:0]     byte_idx, byte_idx_d;
    logic [8*NBYTES-1:0] shadow, shadow_d;

    logic                req_d, dir_d, valid_d, err_d, busy_d;
    logic [6:0]          addr_d;
    logic [7:0]          dat_d;
    logic [8*NBYTES-1:0] sample_d;

    // Poll interval counter; held at zero whenever polling is disabled.
    always_ff @(posedge clk_200k or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (!enable || tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    assign tick = (poll_cnt == CNT_MAX);

    always_ff @(posedge clk_200k or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else if (state_next != state || state == IDLE || state == EMIT) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    assign wd_expired = (wd == WD_MAX);

    always_ff @(posedge clk_200k or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A completing handshake takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tick && enable && !i2c_done) state_next = WR_REQ;
            end
            WR_REQ: begin
                if (i2c_done)        state_next = WR_CLR;
                else if (wd_expired) state_next = IDLE;
            end
            WR_CLR: begin
                if (!i2c_done)       state_next = RD_REQ;
                else if (wd_expired) state_next = IDLE;
            end
            RD_REQ: begin
                if (i2c_done)        state_next = RD_CLR;
                else if (wd_expired) state_next = IDLE;
            end
            RD_CLR: begin
                if (!i2c_done)       state_next = (byte_idx == LAST_IDX) ? EMIT : WR_REQ;
                else if (wd_expired) state_next = IDLE;
            end
            EMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign abort = (state_next == IDLE) &&
                   (state == WR_REQ || state == WR_CLR || state == RD_REQ || state == RD_CLR);

    // Next values of the registered outputs; dir/addr/pointer only change when a request opens.
    always_comb begin
        byte_idx_d = byte_idx;
        shadow_d   = shadow;
        sample_d   = sample;
        valid_d    = 1'b0;
        err_d      = abort;
        busy_d     = (state_next != IDLE);
        req_d      = (state_next == WR_REQ) || (state_next == RD_REQ);
        dir_d      = i2c_dir;
        addr_d     = i2c_addr;
        dat_d      = i2c_dat_to_slv;

        case (state)
            IDLE: begin
                if (state_next == WR_REQ) begin
                    byte_idx_d = '0;
                    shadow_d   = '0;
                end
            end
            RD_REQ: begin
                if (state_next == RD_CLR) begin
                    shadow_d[(32'(LAST_IDX) - 32'(byte_idx)) * 8 +: 8] = i2c_dat_from_slv;
                end
            end
            RD_CLR: begin
                if (state_next == WR_REQ) byte_idx_d = byte_idx + 1'b1;
            end
            EMIT: begin
                sample_d = shadow;
                valid_d  = 1'b1;
            end
            default: begin
            end
        endcase

        if (abort) shadow_d = '0;

        if (state_next == WR_REQ && state != WR_REQ) begin
            dir_d  = 1'b0;
            addr_d = DEV_ADDR;
            dat_d  = REG_BASE + 8'(byte_idx_d);
        end else if (state_next == RD_REQ && state != RD_REQ) begin
            dir_d  = 1'b1;
            addr_d = DEV_ADDR;
        end
    end

    always_ff @(posedge clk_200k or posedge rst) begin
        if (rst) begin
            byte_idx       <= '0;
            shadow         <= '0;
            i2c_req        <= 1'b0;
            i2c_dir        <= 1'b0;
            i2c_addr       <= '0;
            i2c_dat_to_slv <= '0;
            sample         <= '0;
            sample_valid   <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            byte_idx       <= byte_idx_d;
            shadow         <= shadow_d;
            i2c_req        <= req_d;
            i2c_dir        <= dir_d;
            i2c_addr       <= addr_d;
            i2c_dat_to_slv <= dat_d;
            sample         <= sample_d;
            sample_valid   <= valid_d;
            busy           <= busy_d;
            err            <= err_d;
        end
    end

endmodule

// File: tb/tb_i2c_reg_poller.sv
// Directed bench for i2c_reg_poller with a behavioural slave and an expected-result scoreboard.
module tb_i2c_reg_poller;

    localparam logic [7:0] BASE = 8'hFF;

    logic        clk_200k = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        i2c_req, i2c_dir;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_dat_to_slv;
    logic        i2c_done = 1'b0;
    logic [7:0]  i2c_dat_from_slv = 8'h00;
    logic [15:0] sample;
    logic        sample_valid, busy, err;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          req_rises = 0;
    logic [7:0]  key = 8'h00;
    logic        hang_read = 1'b0;
    logic        force_done = 1'b0;
    logic [7:0]  ptr = 8'h00;
    int          lat = 0;
    logic        prev_req = 1'b0, prev_valid = 1'b0, prev_err = 1'b0;
    logic [15:0] last_sample = 16'h0000;

    logic [7:0]  exp_ptr[$];
    logic [15:0] exp_sample[$];

    i2c_reg_poller #(
        .DEV_ADDR (7'h29),
        .REG_BASE (BASE),
        .NBYTES   (2),
        .POLL_DIV (64),
        .TIMEOUT  (32)
    ) dut (
        .clk_200k         (clk_200k),
        .rst              (rst),
        .enable           (enable),
        .i2c_req          (i2c_req),
        .i2c_dir          (i2c_dir),
        .i2c_addr         (i2c_addr),
        .i2c_dat_to_slv   (i2c_dat_to_slv),
        .i2c_done         (i2c_done),
        .i2c_dat_from_slv (i2c_dat_from_slv),
        .sample           (sample),
        .sample_valid     (sample_valid),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk_200k = ~clk_200k;
    always @(posedge clk_200k) cyc++;

    function automatic logic [7:0] slave_mem(input logic [7:0] p);
        case (p)
            8'h00:   return 8'hA5;
            8'h01:   return 8'h3C;
            8'hFF:   return 8'h5A;
            default: return 8'hEE;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic timeout_fail(input string tag, input int budget);
        checks++;
        errors++;
        $error("FAIL %s: no event within %0d cycles, expected one", tag, budget);
    endtask

    // Slave/master model: done is a level driven on the falling edge, dropped once req is gone.
    always @(negedge clk_200k) begin
        if (force_done) begin
            i2c_done = 1'b1;
        end else if (i2c_done) begin
            if (!i2c_req) i2c_done = 1'b0;
        end else if (!i2c_req) begin
            lat = 0;
        end else if (lat < 3) begin
            lat++;
        end else if (!(i2c_dir && hang_read)) begin
            lat = 0;
            i2c_done = 1'b1;
            if (i2c_dir) i2c_dat_from_slv = slave_mem(ptr) ^ key;
            else         ptr = i2c_dat_to_slv;
        end
    end

    // Scoreboard side: pointer on every write request, sample on every strobe.
    always @(negedge clk_200k) begin
        if (i2c_req && !prev_req) begin
            req_rises++;
            check("req_addr", i2c_addr, 32'h29);
            check("req_busy", busy, 1);
            if (!i2c_dir) begin
                check("ptr_expected", exp_ptr.size() != 0, 1);
                if (exp_ptr.size() != 0) check("ptr", i2c_dat_to_slv, exp_ptr.pop_front());
            end
        end
        if (sample_valid) begin
            check("sample_expected", exp_sample.size() != 0, 1);
            if (exp_sample.size() != 0) check("sample", sample, exp_sample.pop_front());
        end
        if (prev_valid) check("valid_one_cycle", sample_valid, 0);
        if (prev_err)   check("err_one_cycle", err, 0);
        prev_req   = i2c_req;
        prev_valid = sample_valid;
        prev_err   = err;
    end

    task automatic queue_poll(input logic [7:0] k);
        logic [7:0] p0, p1;
        key = k;
        p0 = BASE;
        p1 = BASE + 8'd1;
        exp_ptr.push_back(p0);
        exp_ptr.push_back(p1);
        last_sample = {slave_mem(p0) ^ k, slave_mem(p1) ^ k};
        exp_sample.push_back(last_sample);
    endtask

    task automatic wait_rise(input string tag, input logic want_dir, input int budget, output int waited);
        logic last;
        bit   hit;
        last = i2c_req;
        hit = 1'b0;
        waited = 0;
        while (!hit && waited < budget) begin
            @(negedge clk_200k);
            waited++;
            hit = i2c_req && !last && (i2c_dir == want_dir);
            last = i2c_req;
        end
        if (!hit) timeout_fail(tag, budget);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_200k);
            n++;
        end while (!sample_valid && n < budget);
        if (!sample_valid) timeout_fail(tag, budget);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk_200k);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int waited;
        int s1;
        int rises0;

        repeat (2) @(negedge clk_200k);
        #1;
        check("rst_req", i2c_req, 0);
        check("rst_dir", i2c_dir, 0);
        check("rst_addr", i2c_addr, 0);
        check("rst_dat", i2c_dat_to_slv, 0);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk_200k);
        rst = 1'b0;

        // Two back-to-back polls; pointers FF then 00 exercise the 8-bit wrap.
        @(negedge clk_200k);
        enable = 1'b1;
        queue_poll(8'h00);
        wait_rise("start1", 1'b0, 100, waited);
        check("start1_latency", waited, 64);
        check("wr_dir", i2c_dir, 0);
        s1 = cyc;
        wait_valid("poll1", 100);
        check("busy_after_emit", busy, 0);
        queue_poll(8'h0F);
        wait_rise("start2", 1'b0, 100, waited);
        check("poll_period", cyc - s1, 64);
        wait_valid("poll2", 100);

        // Slave never answers the read: watchdog abort, sample retained.
        hang_read = 1'b1;
        exp_ptr.push_back(BASE);
        wait_rise("hang_rd", 1'b1, 150, waited);
        s1 = cyc;
        waited = 0;
        while (!err && waited < 100) begin
            @(negedge clk_200k);
            waited++;
        end
        if (!err) timeout_fail("err_pulse", 100);
        check("timeout_cycles", cyc - s1, 32);
        check("abort_req", i2c_req, 0);
        check("abort_busy", busy, 0);
        check("abort_sample", sample, last_sample);
        @(negedge clk_200k);
        hang_read = 1'b0;
        queue_poll(8'hC3);
        wait_valid("poll_after_abort", 200);

        // Enable dropped during byte 0 read: poll still completes, then nothing.
        queue_poll(8'h5A);
        wait_rise("start_en", 1'b0, 100, waited);
        wait_rise("rd0_en", 1'b1, 50, waited);
        enable = 1'b0;
        wait_valid("poll_en_drop", 100);
        #1;
        rises0 = req_rises;
        idle_cycles(150);
        check("no_req_disabled", req_rises, rises0);
        check("cnt_held", dut.poll_cnt, 0);

        // Reset mid-transaction while the master keeps done high past a tick.
        @(negedge clk_200k);
        enable = 1'b1;
        exp_ptr.push_back(BASE);
        wait_rise("start_rst", 1'b0, 100, waited);
        check("restart_latency", waited, 64);
        waited = 0;
        while (!i2c_done && waited < 20) begin
            @(negedge clk_200k);
            waited++;
        end
        if (!i2c_done) timeout_fail("done_before_rst", 20);
        #1;
        rst = 1'b1;
        force_done = 1'b1;
        #1;
        check("arst_req", i2c_req, 0);
        check("arst_dir", i2c_dir, 0);
        check("arst_addr", i2c_addr, 0);
        check("arst_dat", i2c_dat_to_slv, 0);
        check("arst_sample", sample, 0);
        check("arst_busy", busy, 0);
        @(negedge clk_200k);
        rst = 1'b0;
        #1;
        rises0 = req_rises;
        idle_cycles(150);
        check("no_req_done_high", req_rises, rises0);
        check("idle_done_high", busy, 0);
        force_done = 1'b0;
        queue_poll(8'h99);
        wait_valid("poll_after_rst", 200);

        idle_cycles(2);
        check("ptr_queue_empty", exp_ptr.size(), 0);
        check("sample_queue_empty", exp_sample.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
